// File: rtl/aes_iter_ctrl.sv
// Iterative AES-128 controller: sequences a shared round/key-expansion datapath over NR rounds.
// Latency: 11 cycles from the accept edge to the first out_valid cycle; one block in flight, 12-cycle minimum period.
// Backpressure: ciphertext held in DONE until out_ready; in_ready stays low while a block is in flight.
module aes_iter_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_text,
    input  logic [127:0] in_key,
    output logic [127:0] rnd_state,
    output logic [127:0] rnd_key,
    output logic [7:0]   rnd_rcon,
    output logic         rnd_final,
    output logic [3:0]   rnd_idx,
    input  logic [127:0] rk_nxt,
    input  logic [127:0] rnd_state_nxt,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_text,
    output logic         busy
);

    localparam logic [3:0] NR_L = 4'(NR);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t         fsm_q;
    fsm_t         fsm_d;
    logic [127:0] state_q;
    logic [127:0] key_q;
    logic [7:0]   rcon_q;
    logic [3:0]   round_q;
    logic         accept;
    logic         last_round;

    // GF(2^8) doubling used to step the round constant.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    assign last_round = (round_q == NR_L);

    // Registered state and key feed the shared datapath; the ciphertext is the state register itself.
    assign rnd_state = state_q;
    assign rnd_key   = key_q;
    assign rnd_rcon  = rcon_q;
    assign out_text  = state_q;

    // Next-state and control decode; outputs depend on registered state (and rst) only.
    always_comb begin
        fsm_d     = fsm_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        rnd_final = 1'b0;
        rnd_idx   = 4'd0;
        accept    = 1'b0;
        if (!rst) begin
            busy = (fsm_q != IDLE);
            case (fsm_q)
                IDLE: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        accept = 1'b1;
                        fsm_d  = RUN;
                    end
                end
                RUN: begin
                    rnd_idx   = round_q;
                    rnd_final = last_round;
                    if (last_round) begin
                        fsm_d = DONE;
                    end
                end
                DONE: begin
                    out_valid = 1'b1;
                    if (out_ready) begin
                        fsm_d = IDLE;
                    end
                end
                default: fsm_d = IDLE;
            endcase
        end
    end

    // FSM, cipher state, round key, round constant and round counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            rcon_q  <= 8'h00;
            round_q <= 4'd0;
        end else begin
            fsm_q <= fsm_d;
            if (accept) begin
                // Initial AddRoundKey is folded into the load.
                state_q <= in_text ^ in_key;
                key_q   <= in_key;
                rcon_q  <= 8'h01;
                round_q <= 4'd1;
            end else if (fsm_q == RUN) begin
                state_q <= rnd_state_nxt;
                key_q   <= rk_nxt;
                rcon_q  <= xtime(rcon_q);
                round_q <= last_round ? 4'd0 : (round_q + 4'd1);
            end
        end
    end

endmodule

// File: tb/tb_aes_iter_ctrl.sv
// Bench for aes_iter_ctrl: supplies a behavioural AES round/key datapath and checks the controller.
// Known-answer table, hand sequences for backpressure, ignored input, reset and back-to-back, then random traffic.
// Random phase predicts handshakes and ciphertexts from a transaction-level model.
module tb_aes_iter_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_text;
    logic [127:0] in_key;
    logic [127:0] rnd_state;
    logic [127:0] rnd_key;
    logic [7:0]   rnd_rcon;
    logic         rnd_final;
    logic [3:0]   rnd_idx;
    logic [127:0] rk_nxt;
    logic [127:0] rnd_state_nxt;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_text;
    logic         busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_iter_ctrl #(.NR(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_text      (in_text),
        .in_key       (in_key),
        .rnd_state    (rnd_state),
        .rnd_key      (rnd_key),
        .rnd_rcon     (rnd_rcon),
        .rnd_final    (rnd_final),
        .rnd_idx      (rnd_idx),
        .rk_nxt       (rk_nxt),
        .rnd_state_nxt(rnd_state_nxt),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_text     (out_text),
        .busy         (busy)
    );

    // ---------------- behavioural AES helpers ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv, e, b;
        e = 8'hfe;
        inv = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            inv = gmul(inv, inv);
            if (e[i]) inv = gmul(inv, x);
        end
        b = inv;
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w3, t, n0, n1, n2, n3;
        w3 = k[127:96];
        t  = {sbox(w3[7:0]), sbox(w3[31:24]), sbox(w3[23:16]), sbox(w3[15:8]) ^ rc};
        n0 = k[31:0] ^ t;
        n1 = k[63:32] ^ n0;
        n2 = k[95:64] ^ n1;
        n3 = k[127:96] ^ n2;
        return {n3, n2, n1, n0};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic fin);
        logic [7:0]   sb [16];
        logic [7:0]   t  [16];
        logic [7:0]   o  [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) sb[i] = sbox(s[8*i +: 8]);
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                t[4*c+rr] = sb[4*((c+rr)%4)+rr];
        for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            if (fin) begin
                o[4*c] = a0; o[4*c+1] = a1; o[4*c+2] = a2; o[4*c+3] = a3;
            end else begin
                o[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                o[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                o[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                o[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) r[8*i +: 8] = o[i] ^ rk[8*i +: 8];
        return r;
    endfunction

    // Whole-block reference encryption.
    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] s, k;
        logic [7:0]   rc;
        s = pt ^ key; k = key; rc = 8'h01;
        for (int i = 1; i <= 10; i++) begin
            k  = key_step(k, rc);
            s  = aes_round(s, k, i == 10);
            rc = gmul(rc, 8'h02);
        end
        return s;
    endfunction

    // FIPS hex strings list byte 0 first; the bus carries byte 0 at bits [7:0].
    function automatic logic [127:0] bswap(input logic [127:0] x);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = x[8*(15-i) +: 8];
        return o;
    endfunction

    // Round datapath the controller drives.
    assign rk_nxt        = key_step(rnd_key, rnd_rcon);
    assign rnd_state_nxt = aes_round(rnd_state, rk_nxt, rnd_final);

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
    } vec_t;

    vec_t       vecs [2];
    logic [7:0] rcon_exp [10];

    task automatic start_block(input logic [127:0] pt, input logic [127:0] key, input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin @(negedge clk); n++; end
        chk({tag, " in_ready before accept"}, 128'(in_ready), 128'(1'b1));
        in_valid = 1'b1; in_text = pt; in_key = key;
        @(negedge clk);
        in_valid = 1'b0;
        in_text  = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_key   = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    // Called one cycle after the accept edge; n counts cycles since that edge.
    task automatic wait_out(output int n);
        n = 1;
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
    endtask

    task automatic run_block(input vec_t v, input string tag);
        int n;
        out_ready = 1'b1;
        start_block(v.pt, v.key, tag);
        n = 1;
        while (!out_valid && n < 40) begin
            if (n <= 10) begin
                chk({tag, " rnd_idx"},   128'(rnd_idx),   128'(n));
                chk({tag, " rnd_rcon"},  128'(rnd_rcon),  128'(rcon_exp[n-1]));
                chk({tag, " rnd_final"}, 128'(rnd_final), 128'(n == 10));
            end
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, 128'(n), 128'(11));
        chk({tag, " ciphertext"}, out_text, v.ct);
        @(negedge clk);
        chk({tag, " out_valid after take"}, 128'(out_valid), 128'(1'b0));
        chk({tag, " in_ready after take"},  128'(in_ready),  128'(1'b1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int n, nacc, nout, ups, nblk;
        int acc [4];
        logic [127:0] outs [2];
        logic pending;
        int since;
        logic [127:0] exp_ct;
        logic m_ovld;

        vecs[0] = '{pt:  bswap(128'h3243f6a8885a308d313198a2e0370734),
                    key: bswap(128'h2b7e151628aed2a6abf7158809cf4f3c),
                    ct:  bswap(128'h3925841d02dc09fbdc118597196a0b32)};
        vecs[1] = '{pt:  bswap(128'h00112233445566778899aabbccddeeff),
                    key: bswap(128'h000102030405060708090a0b0c0d0e0f),
                    ct:  bswap(128'h69c4e0d86a7b0430d8cdb78070b4c55a)};
        rcon_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_text = '0; in_key = '0;
        repeat (3) @(negedge clk);
        chk("reset in_ready",  128'(in_ready),  128'(1'b0));
        chk("reset out_valid", 128'(out_valid), 128'(1'b0));
        chk("reset busy",      128'(busy),      128'(1'b0));
        chk("reset out_text",  out_text,        128'(0));
        chk("reset rnd_key",   rnd_key,         128'(0));
        chk("reset rnd_rcon",  128'(rnd_rcon),  128'(0));
        chk("reset rnd_idx",   128'(rnd_idx),   128'(0));
        chk("reset rnd_final", 128'(rnd_final), 128'(0));
        rst = 1'b0;
        #1;
        chk("in_ready after reset", 128'(in_ready), 128'(1'b1));

        // Known-answer table.
        for (int i = 0; i < 2; i++) run_block(vecs[i], $sformatf("kat%0d", i));

        // Backpressure: out_ready low for 5 cycles past the first out_valid cycle.
        out_ready = 1'b0;
        start_block(vecs[0].pt, vecs[0].key, "bp");
        wait_out(n);
        chk("bp latency", 128'(n), 128'(11));
        chk("bp ciphertext", out_text, vecs[0].ct);
        in_valid = 1'b1; in_text = vecs[1].pt; in_key = vecs[1].key;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp out_valid held", 128'(out_valid), 128'(1'b1));
            chk("bp out_text held",  out_text,        vecs[0].ct);
            chk("bp in_ready low",   128'(in_ready),  128'(1'b0));
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp release out_valid", 128'(out_valid), 128'(1'b0));
        chk("bp release in_ready",  128'(in_ready),  128'(1'b1));
        chk("bp release busy",      128'(busy),      128'(1'b0));
        in_valid = 1'b0;
        @(negedge clk);

        // Ignored input during RUN.
        start_block(vecs[1].pt, vecs[1].key, "ign");
        n = 0;
        while (rnd_idx != 4'd4 && n < 20) begin @(negedge clk); n++; end
        chk("ign rnd_idx", 128'(rnd_idx), 128'(4));
        chk("ign in_ready low", 128'(in_ready), 128'(1'b0));
        in_valid = 1'b1; in_text = vecs[0].pt; in_key = vecs[0].key;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(n);
        chk("ign ciphertext", out_text, vecs[1].ct);
        @(negedge clk);
        chk("ign idle busy", 128'(busy), 128'(1'b0));
        @(negedge clk);
        chk("ign no second block", 128'(busy), 128'(1'b0));

        // Reset at round 5.
        start_block(vecs[0].pt, vecs[0].key, "rst");
        n = 0;
        while (rnd_idx != 4'd5 && n < 20) begin @(negedge clk); n++; end
        chk("rst rnd_idx", 128'(rnd_idx), 128'(5));
        rst = 1'b1;
        #1;
        chk("rst held in_ready",  128'(in_ready),  128'(1'b0));
        chk("rst held out_valid", 128'(out_valid), 128'(1'b0));
        chk("rst held busy",      128'(busy),      128'(1'b0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst released in_ready", 128'(in_ready), 128'(1'b1));
        chk("rst released busy",     128'(busy),     128'(1'b0));
        ups = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) ups++;
        end
        chk("rst abandoned block out_valid count", 128'(ups), 128'(0));
        run_block(vecs[0], "post-rst");

        // Back-to-back with in_valid and out_ready held high.
        in_valid = 1'b1; in_text = vecs[0].pt; in_key = vecs[0].key; out_ready = 1'b1;
        nacc = 0; nout = 0; acc = '{0, 0, 0, 0};
        for (int c = 0; c < 80 && nout < 2; c++) begin
            if (out_valid) begin outs[nout] = out_text; nout++; end
            if (in_valid && in_ready && nacc < 4) begin acc[nacc] = cyc; nacc++; end
            else if (nacc == 1) begin in_text = vecs[1].pt; in_key = vecs[1].key; end
            else if (nacc >= 2) in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("b2b outputs", 128'(nout), 128'(2));
        chk("b2b ct0", outs[0], vecs[0].ct);
        chk("b2b ct1", outs[1], vecs[1].ct);
        chk("b2b accept spacing", 128'(acc[1] - acc[0]), 128'(12));
        @(negedge clk);

        // Random traffic against a transaction-level model: a block is done 11 cycles after accept.
        pending = 1'b0; since = 0; exp_ct = '0; nblk = 0;
        for (int c = 0; c < 420; c++) begin
            m_ovld = pending && (since >= 11);
            chk("rand in_ready",  128'(in_ready),  128'(!pending));
            chk("rand out_valid", 128'(out_valid), 128'(m_ovld));
            if (m_ovld) chk("rand ciphertext", out_text, exp_ct);
            in_valid  = (c < 400) && ($urandom_range(0, 3) == 0);
            in_text   = {$urandom(), $urandom(), $urandom(), $urandom()};
            in_key    = {$urandom(), $urandom(), $urandom(), $urandom()};
            out_ready = (c >= 400) || ($urandom_range(0, 2) != 0);
            if (m_ovld && out_ready) begin
                pending = 1'b0;
            end else if (!pending && in_valid) begin
                pending = 1'b1;
                since   = 0;
                exp_ct  = aes_ref(in_text, in_key);
                nblk++;
            end
            @(negedge clk);
            if (pending) since++;
        end
        chk("rand drained", 128'(pending), 128'(1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_iter_ctrl.md
# aes_iter_ctrl

Iterative AES-128 encryption controller. It sequences one shared combinational round datapath and one shared key-expansion datapath over 10 rounds, holding the cipher state and round key in registers between rounds. It accepts a plaintext/key pair through a valid/ready handshake and returns the ciphertext the same way. It sits between the block-level stream interface and the round logic, which is built from the column/row unpack helpers, SubBytes/ShiftRows/MixColumns and the key expander.

## Interface
Parameters:
- NR, 10, number of rounds. Only 10 (AES-128) is supported.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  a plaintext/key pair is offered.
- in_ready  out  1  controller accepts the pair.
- in_text  in  128  plaintext, column-major: col c = bits [32c +: 32]; byte r of a column = bits [8r +: 8] within it.
- in_key  in  128  cipher key, same packing.
- rnd_state  out  128  current state register, fed to the round datapath.
- rnd_key  out  128  current round key k(r-1), fed to the key expander.
- rnd_rcon  out  8  round constant for the expansion k(r-1) -> k(r).
- rnd_final  out  1  current round is the last one; the datapath skips MixColumns.
- rnd_idx  out  4  current round number, 1..NR while running, 0 otherwise.
- rk_nxt  in  128  key-expander result k(r), combinational from rnd_key and rnd_rcon.
- rnd_state_nxt  in  128  round-datapath result, combinational from rnd_state, rk_nxt and rnd_final.
- out_valid  out  1  ciphertext available.
- out_ready  in  1  consumer takes the ciphertext.
- out_text  out  128  ciphertext, same packing.
- busy  out  1  a block is in flight (RUN or DONE).

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - in_ready = 1.
  - On the edge with in_valid & in_ready:
    - state_q <= in_text ^ in_key (initial AddRoundKey is done internally).
    - key_q <= in_key.
    - rcon_q <= 8'h01.
    - round_q <= 1.
    - Go to RUN.
- **RUN**
  - in_ready = 0.
  - Every cycle:
    - state_q <= rnd_state_nxt.
    - key_q <= rk_nxt.
    - rcon_q <= xtime(rcon_q), where xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00).
  - rnd_final = (round_q == NR).
  - If round_q == NR: go to DONE and clear round_q to 0. Otherwise round_q <= round_q + 1.
  - Resulting rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
- **DONE**
  - out_valid = 1 and out_text = state_q.
  - out_text stays stable until out_ready is sampled high.
  - On out_valid & out_ready: go to IDLE.
  - No new block is accepted in DONE, even if in_valid is high.
- Outside RUN: rnd_final = 0 and rnd_idx = 0.
- In RUN: rnd_idx = round_q.
- busy = (fsm != IDLE).
- in_text and in_key are ignored whenever in_ready = 0.
- rnd_state_nxt and rk_nxt are ignored outside RUN.
- Reset:
  - fsm = IDLE; state_q, key_q, out_text = 0; rcon_q = 0; round_q = 0.
  - While rst is high: out_valid = 0, in_ready = 0, busy = 0.
  - A reset mid-block abandons it. No out_valid is produced for it.
  - in_ready = 1 in the first cycle after rst falls.
- Control outputs are decoded from registered state only. There is no combinational path from in_valid or out_ready to any output.

## Timing
- Accept edge = edge E0. Rounds 1..10 occupy the cycles after E0..E9.
- The DONE transition happens at edge E10. out_valid is high from the cycle after E10.
- Latency: 11 cycles from the accept edge to the first out_valid cycle.
- With out_ready held high: out_valid lasts 1 cycle, IDLE follows, and the next accept can occur 1 cycle later.
- Minimum period is 12 cycles per block.
- The round datapath must settle within one clock: rk_nxt -> rnd_state_nxt is in the critical path.

## Test plan
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 (byte 0 at bits [7:0]) -> ct 3925841d02dc09fbdc118597196a0b32, with out_valid exactly 11 cycles after accept.
- FIPS-197 App. C.1: key 000102...0f, pt 00112233...ff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a.
  - rnd_rcon probed per round must equal 01,02,04,08,10,20,40,80,1b,36.
  - rnd_final must be high only while rnd_idx = 10.
- Backpressure: hold out_ready = 0 for 5 cycles after out_valid -> out_valid and out_text stay stable; in_ready stays 0 even with in_valid = 1. Release -> IDLE next cycle.
- Ignored input: pulse in_valid with a different pt/key during RUN (rnd_idx = 4) -> first ciphertext unchanged and no second block starts.
- Reset at rnd_idx = 5 for 1 cycle:
  - out_valid never rises for that block.
  - in_ready = 1 in the cycle after rst falls.
  - A fresh App. B block then completes correctly.
- Back-to-back: in_valid and out_ready held high with two vectors -> both correct, accept edges exactly 12 cycles apart.
